// File: rtl/tx_packetizer_if.sv
`default_nettype none
// ============================================================================
// Module      : tx_packetizer_if
// Description : Bundles the start/response inputs, the echo byte stream and
//               the outgoing byte stream of tx_packetizer.
//               slave  = packetizer side, master = driver/consumer side.
// Revision    : 1.0  initial release
// ============================================================================
interface tx_packetizer_if #(
    parameter int RESULT_BYTES = 8
);
    logic                      start_i;
    logic                      ready_o;
    logic [7:0]                opcode_i;
    logic [15:0]               len_i;
    logic [8*RESULT_BYTES-1:0] result_i;
    logic                      echo_i;
    logic [7:0]                echo_data_i;
    logic                      echo_valid_i;
    logic                      echo_ready_o;
    logic [7:0]                data_o;
    logic                      valid_o;
    logic                      ready_i;
    logic                      busy_o;
    logic                      done_o;

    modport slave (
        input  start_i, opcode_i, len_i, result_i, echo_i,
        input  echo_data_i, echo_valid_i, ready_i,
        output ready_o, echo_ready_o, data_o, valid_o, busy_o, done_o
    );

    modport master (
        output start_i, opcode_i, len_i, result_i, echo_i,
        output echo_data_i, echo_valid_i, ready_i,
        input  ready_o, echo_ready_o, data_o, valid_o, busy_o, done_o
    );
endinterface
`default_nettype wire

// File: rtl/tx_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : tx_packetizer
// Description : Transmit-side framer. Sends opcode, reserved byte, 16-bit
//               length field (LSB first) and then the payload, taken either
//               from the latched result word or passed through from the echo
//               byte stream. Optional macro TX_CHECKSUM_EN appends an XOR
//               checksum byte covering every preceding frame byte.
// Revision    : 1.0  initial release
// ============================================================================
module tx_packetizer #(
    parameter int         RESULT_BYTES = 8,
    parameter logic [7:0] RSVD_BYTE    = 8'h00
) (
    input  wire logic       clk,
    input  wire logic       rst,
    tx_packetizer_if.slave  bus
);

`ifdef TX_CHECKSUM_EN
    localparam logic [15:0] C_HDR_BYTES = 16'd5;   // 4 header bytes + checksum
`else
    localparam logic [15:0] C_HDR_BYTES = 16'd4;
`endif
    // Largest echo length whose length field still fits in 16 bits.
    localparam logic [15:0] C_ECHO_MAX = 16'hFFFF - C_HDR_BYTES;
    localparam logic [15:0] C_RES_MAX  = 16'(RESULT_BYTES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HDR_OP    = 3'd1,
        S_HDR_RSV   = 3'd2,
        S_HDR_LSB   = 3'd3,
        S_HDR_MSB   = 3'd4,
        S_PAYLOAD   = 3'd5,
        S_ECHO_PASS = 3'd6
`ifdef TX_CHECKSUM_EN
        ,
        S_CKSUM     = 3'd7
`endif
    } state_t;

    state_t                    state_q, state_d;
    logic [7:0]                opcode_q;
    logic                      echo_q;
    logic [8*RESULT_BYTES-1:0] result_q;     // shifts down one byte per payload transfer
    logic [15:0]               len_q;        // clamped payload length L
    logic [15:0]               field_q;      // length field F sent in the header
    logic [15:0]               cnt_q;        // payload bytes already transferred
`ifdef TX_CHECKSUM_EN
    logic [7:0]                csum_q;       // running XOR of transferred bytes
`endif

    logic [15:0] w_len_clamp;
    logic        w_start;
    logic        w_last;
    logic        w_xfer;
    logic [7:0]  w_data;
    logic        w_valid;
    logic        w_echo_ready;
    logic        w_done;

    assign w_start = (state_q == S_IDLE) && bus.start_i;
    assign w_last  = (cnt_q == (len_q - 16'd1));
    assign w_xfer  = w_valid && bus.ready_i;

    // Clamp the requested length to what the selected payload source can supply.
    always_comb begin
        w_len_clamp = bus.len_i;
        if (bus.echo_i) begin
            if (bus.len_i > C_ECHO_MAX) w_len_clamp = C_ECHO_MAX;
        end else begin
            if (bus.len_i > C_RES_MAX) w_len_clamp = C_RES_MAX;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state and output decode; outputs are derived from registered
    // frame fields so data_o/valid_o stay stable while the sink stalls.
    always_comb begin
        state_d      = state_q;
        w_data       = 8'h00;
        w_valid      = 1'b0;
        w_echo_ready = 1'b0;
        w_done       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) state_d = S_HDR_OP;
            end
            S_HDR_OP: begin
                w_data  = opcode_q;
                w_valid = 1'b1;
                if (bus.ready_i) state_d = S_HDR_RSV;
            end
            S_HDR_RSV: begin
                w_data  = RSVD_BYTE;
                w_valid = 1'b1;
                if (bus.ready_i) state_d = S_HDR_LSB;
            end
            S_HDR_LSB: begin
                w_data  = field_q[7:0];
                w_valid = 1'b1;
                if (bus.ready_i) state_d = S_HDR_MSB;
            end
            S_HDR_MSB: begin
                w_data  = field_q[15:8];
                w_valid = 1'b1;
                if (bus.ready_i) begin
                    if (len_q == 16'd0) begin
`ifdef TX_CHECKSUM_EN
                        state_d = S_CKSUM;
`else
                        state_d = S_IDLE;
                        w_done  = 1'b1;
`endif
                    end else if (echo_q) begin
                        state_d = S_ECHO_PASS;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                w_data  = result_q[7:0];
                w_valid = 1'b1;
                if (bus.ready_i && w_last) begin
`ifdef TX_CHECKSUM_EN
                    state_d = S_CKSUM;
`else
                    state_d = S_IDLE;
                    w_done  = 1'b1;
`endif
                end
            end
            S_ECHO_PASS: begin
                // Combinational pass-through: the echo source sees the sink's ready.
                w_data       = bus.echo_data_i;
                w_valid      = bus.echo_valid_i;
                w_echo_ready = bus.ready_i;
                if (bus.echo_valid_i && bus.ready_i && w_last) begin
`ifdef TX_CHECKSUM_EN
                    state_d = S_CKSUM;
`else
                    state_d = S_IDLE;
                    w_done  = 1'b1;
`endif
                end
            end
`ifdef TX_CHECKSUM_EN
            S_CKSUM: begin
                w_data  = csum_q;
                w_valid = 1'b1;
                if (bus.ready_i) begin
                    state_d = S_IDLE;
                    w_done  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Frame fields: latched on start acceptance, advanced on each transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode_q <= 8'h00;
            echo_q   <= 1'b0;
            result_q <= '0;
            len_q    <= 16'd0;
            field_q  <= 16'd0;
            cnt_q    <= 16'd0;
`ifdef TX_CHECKSUM_EN
            csum_q   <= 8'h00;
`endif
        end else if (w_start) begin
            opcode_q <= bus.opcode_i;
            echo_q   <= bus.echo_i;
            result_q <= bus.result_i;
            len_q    <= w_len_clamp;
            field_q  <= w_len_clamp + C_HDR_BYTES;
            cnt_q    <= 16'd0;
`ifdef TX_CHECKSUM_EN
            csum_q   <= 8'h00;
`endif
        end else if (w_xfer) begin
`ifdef TX_CHECKSUM_EN
            csum_q <= csum_q ^ w_data;
`endif
            if ((state_q == S_PAYLOAD) || (state_q == S_ECHO_PASS)) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (state_q == S_PAYLOAD) begin
                result_q <= result_q >> 8;
            end
        end
    end

    assign bus.data_o       = w_data;
    assign bus.valid_o      = w_valid;
    assign bus.echo_ready_o = w_echo_ready;
    assign bus.done_o       = w_done;
    assign bus.ready_o      = (state_q == S_IDLE);
    assign bus.busy_o       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tx_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_packetizer
// Description : Self-checking bench for tx_packetizer. A frame table drives
//               result/echo frames; a scoreboard queue holds the expected
//               byte stream, popped by a monitor on every handshake. Hand
//               sequences cover held start and reset mid-payload.
// Revision    : 1.0  initial release
// ============================================================================
module tb_tx_packetizer;

    localparam int RB = 8;
`ifdef TX_CHECKSUM_EN
    localparam int C_HDR = 5;
`else
    localparam int C_HDR = 4;
`endif

    typedef struct {
        logic [7:0]  op;
        logic [15:0] len;
        logic [63:0] res;
        logic        echo;
        int          rmode;   // 0: ready always, 1: 1,0,0 pattern, 2: random
        int          exp_l;   // expected clamped payload length
    } vec_t;

    typedef struct {
        logic [7:0] b;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tx_packetizer_if #(.RESULT_BYTES(RB)) bus ();

    tx_packetizer #(
        .RESULT_BYTES (RB),
        .RSVD_BYTE    (8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t       exp_q[$];
    logic [7:0] cap_q[$];
    logic [7:0] echo_src[4];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         done_cnt = 0;
    logic       echo_take = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int         echo_idx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Build the expected frame for one accepted start and queue it.
    task automatic push_frame(input vec_t v);
        int         l;
        logic [15:0] f;
        logic [7:0] by[$];
        logic [7:0] x;
        if (v.echo) l = (int'(v.len) > 65535 - C_HDR) ? 65535 - C_HDR : int'(v.len);
        else        l = (int'(v.len) > RB) ? RB : int'(v.len);
        f = 16'(l + C_HDR);
        by.push_back(v.op);
        by.push_back(8'h00);
        by.push_back(f[7:0]);
        by.push_back(f[15:8]);
        for (int k = 0; k < l; k++) begin
            if (v.echo) by.push_back((k < 4) ? echo_src[k] : 8'h00);
            else        by.push_back(v.res[8*k +: 8]);
        end
        x = 8'h00;
        foreach (by[i]) x = x ^ by[i];
`ifdef TX_CHECKSUM_EN
        by.push_back(x);
`endif
        foreach (by[i]) exp_q.push_back('{b: by[i], last: (i == by.size() - 1)});
    endtask

    // Monitor: sampled on the falling edge, describing the handshake that
    // completes on the following rising edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            echo_take  = 1'b0;
        end else begin
            exp_t e;
            if (prev_stall) begin
                check("hold_valid", {31'd0, bus.valid_o}, 32'd1);
                check("hold_data", {24'd0, bus.data_o}, {24'd0, prev_data});
            end
            if (bus.valid_o && bus.ready_i) begin
                cap_q.push_back(bus.data_o);
                check("byte_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("data", {24'd0, bus.data_o}, {24'd0, e.b});
                    check("done_on_last", {31'd0, bus.done_o}, {31'd0, e.last});
                end
            end else begin
                check("done_without_xfer", {31'd0, bus.done_o}, 32'd0);
            end
            if (bus.done_o) done_cnt++;
            echo_take  = bus.echo_valid_i && bus.echo_ready_o;
            prev_stall = bus.valid_o && !bus.ready_i;
            prev_data  = bus.data_o;
        end
    end

    task automatic drive_ready(input int rmode, input int cyc);
        case (rmode)
            0:       bus.ready_i = 1'b1;
            1:       bus.ready_i = ((cyc % 3) == 0);
            default: bus.ready_i = 1'($urandom_range(0, 1));
        endcase
    endtask

    // Echo source: holds a presented byte until consumed, random gaps otherwise.
    task automatic drive_echo(input logic en, input logic took);
        if (!en) begin
            bus.echo_valid_i = 1'b0;
        end else if (bus.echo_valid_i && !took) begin
            bus.echo_valid_i = 1'b1;
        end else if (echo_idx < 4 && $urandom_range(0, 2) != 0) begin
            bus.echo_valid_i = 1'b1;
            bus.echo_data_i  = echo_src[echo_idx];
        end else begin
            bus.echo_valid_i = 1'b0;
        end
    endtask

    // Send one table frame and wait for its done pulse (bounded).
    task automatic run_frame(input vec_t v, input string tag);
        int   d0;
        int   cyc;
        logic took;
        cap_q.delete();
        d0       = done_cnt;
        echo_idx = 0;
        bus.opcode_i = v.op;
        bus.len_i    = v.len;
        bus.result_i = v.res;
        bus.echo_i   = v.echo;
        bus.start_i  = 1'b1;
        bus.echo_valid_i = 1'b0;
        push_frame(v);
        tick();
        // Scramble the inputs so only latched values can reach the frame.
        bus.start_i  = 1'b0;
        bus.opcode_i = ~v.op;
        bus.len_i    = 16'hFFFF;
        bus.result_i = ~v.res;
        bus.echo_i   = ~v.echo;
        cyc  = 0;
        took = 1'b0;
        while (done_cnt == d0 && cyc < 300) begin
            drive_ready(v.rmode, cyc);
            drive_echo(v.echo, took);
            tick();
            took = echo_take;
            if (took) echo_idx++;
            cyc++;
        end
        check({tag, "_timeout"}, {31'd0, cyc < 300}, 32'd1);
        bus.echo_valid_i = 1'b0;
        @(negedge clk);
        check({tag, "_ready_after_done"}, {31'd0, bus.ready_o}, 32'd1);
        check({tag, "_echo_ready_idle"}, {31'd0, bus.echo_ready_o}, 32'd0);
        tick();
        check({tag, "_done_count"}, done_cnt - d0, 32'd1);
        check({tag, "_nbytes"}, cap_q.size(), v.exp_l + C_HDR);
        if (cap_q.size() >= 4)
            check({tag, "_len_field"}, {16'd0, cap_q[3], cap_q[2]}, 32'(v.exp_l + C_HDR));
        check({tag, "_sb_empty"}, exp_q.size(), 32'd0);
        if (v.echo) check({tag, "_echo_consumed"}, echo_idx, v.exp_l);
    endtask

    initial begin
        vec_t        vt[7];
        logic [7:0]  gold0[$];
        vec_t        h;
        int          d0;
        int          cyc;

        echo_src[0] = 8'h11; echo_src[1] = 8'h22;
        echo_src[2] = 8'h33; echo_src[3] = 8'h44;

        vt[0] = '{8'hA1, 16'd4,  64'h0000_0000_DEAD_BEEF, 1'b0, 0, 4};
        vt[1] = '{8'hA1, 16'd4,  64'h0000_0000_DEAD_BEEF, 1'b0, 1, 4};
        vt[2] = '{8'h5C, 16'd12, 64'h8877_6655_4433_2211, 1'b0, 2, 8};
        vt[3] = '{8'h33, 16'd0,  64'h1234_5678_9ABC_DEF0, 1'b0, 0, 0};
        vt[4] = '{8'hE7, 16'd3,  64'h0,                   1'b1, 0, 3};
        vt[5] = '{8'h01, 16'd1,  64'h0000_0000_0000_00FF, 1'b0, 0, 1};
        vt[6] = '{8'h7E, 16'd8,  64'hF0E1_D2C3_B4A5_9687, 1'b0, 1, 8};

`ifdef TX_CHECKSUM_EN
        gold0 = '{8'hA1, 8'h00, 8'h09, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h8A};
`else
        gold0 = '{8'hA1, 8'h00, 8'h08, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`endif

        bus.start_i      = 1'b0;
        bus.opcode_i     = 8'h00;
        bus.len_i        = 16'd0;
        bus.result_i     = '0;
        bus.echo_i       = 1'b0;
        bus.echo_data_i  = 8'h00;
        bus.echo_valid_i = 1'b0;
        bus.ready_i      = 1'b1;

        // Reset state.
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_ready_o", {31'd0, bus.ready_o}, 32'd1);
        check("rst_valid_o", {31'd0, bus.valid_o}, 32'd0);
        check("rst_data_o", {24'd0, bus.data_o}, 32'd0);
        check("rst_echo_ready_o", {31'd0, bus.echo_ready_o}, 32'd0);
        check("rst_busy_o", {31'd0, bus.busy_o}, 32'd0);
        check("rst_done_o", {31'd0, bus.done_o}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Table-driven frames.
        for (int i = 0; i < 7; i++) begin
            run_frame(vt[i], $sformatf("vec%0d", i));
            if (i == 0) begin
                check("vec0_gold_size", cap_q.size(), gold0.size());
                for (int k = 0; k < gold0.size() && k < cap_q.size(); k++)
                    check($sformatf("vec0_gold_byte%0d", k), {24'd0, cap_q[k]}, {24'd0, gold0[k]});
            end
            if (i == 5) begin
`ifdef TX_CHECKSUM_EN
                if (cap_q.size() == 6) check("vec5_checksum", {24'd0, cap_q[5]}, 32'hF8);
`else
                if (cap_q.size() == 5) check("vec5_payload", {24'd0, cap_q[4]}, 32'hFF);
`endif
            end
        end

        // Held start: a second frame begins the cycle after done_o.
        h = '{8'h5A, 16'd2, 64'h0000_0000_0000_BBAA, 1'b0, 0, 2};
        push_frame(h);
        push_frame(h);
        d0 = done_cnt;
        bus.opcode_i = h.op; bus.len_i = h.len; bus.result_i = h.res; bus.echo_i = 1'b0;
        bus.ready_i  = 1'b1;
        bus.start_i  = 1'b1;
        cyc = 0;
        while (done_cnt == d0 && cyc < 100) begin tick(); cyc++; end
        check("held_first_timeout", {31'd0, cyc < 100}, 32'd1);
        @(negedge clk);
        check("held_ready_after_done", {31'd0, bus.ready_o}, 32'd1);
        check("held_valid_gap", {31'd0, bus.valid_o}, 32'd0);
        tick();
        bus.start_i = 1'b0;
        @(negedge clk);
        check("held_restart_valid", {31'd0, bus.valid_o}, 32'd1);
        check("held_restart_data", {24'd0, bus.data_o}, 32'h5A);
        cyc = 0;
        while (done_cnt < d0 + 2 && cyc < 100) begin tick(); cyc++; end
        check("held_second_timeout", {31'd0, cyc < 100}, 32'd1);
        tick();
        check("held_sb_empty", exp_q.size(), 32'd0);

        // Reset after the second payload byte abandons the frame.
        h = '{8'h77, 16'd4, 64'h0000_0000_4433_2211, 1'b0, 0, 4};
        cap_q.delete();
        push_frame(h);
        bus.opcode_i = h.op; bus.len_i = h.len; bus.result_i = h.res; bus.echo_i = 1'b0;
        bus.start_i  = 1'b1;
        tick();
        bus.start_i = 1'b0;
        cyc = 0;
        while (cap_q.size() < 6 && cyc < 50) begin tick(); cyc++; end
        check("rstmid_reach_timeout", {31'd0, cyc < 50}, 32'd1);
        d0  = done_cnt;
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("rstmid_valid_o", {31'd0, bus.valid_o}, 32'd0);
        check("rstmid_ready_o", {31'd0, bus.ready_o}, 32'd1);
        check("rstmid_busy_o", {31'd0, bus.busy_o}, 32'd0);
        check("rstmid_done_o", {31'd0, bus.done_o}, 32'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("rstmid_no_done", done_cnt - d0, 32'd0);
        run_frame(vt[0], "post_rst");
        check("post_rst_gold_size", cap_q.size(), gold0.size());
        for (int k = 0; k < gold0.size() && k < cap_q.size(); k++)
            check($sformatf("post_rst_gold_byte%0d", k), {24'd0, cap_q[k]}, {24'd0, gold0[k]});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
